sm_encode_stream: RTL

Streaming encoder from two's-complement to sign-magnitude. It feeds the CNN datapath's sign-magnitude adder tree.
- Accepts one two's-complement sample per cycle on a valid/ready input.
- Emits the sign-magnitude equivalent on a valid/ready output.
- Saturates the one unrepresentable value and counts saturation events.
- A 2-entry skid buffer decouples the backpressure path.

---
 rtl/sm_pkg.sv | 42 ++++
 rtl/sm_encode_stream_skid.sv | 79 +++++++
 rtl/sm_encode_stream.sv | 57 +++++
 3 files changed

// File: rtl/sm_pkg.sv
// Shared definitions for the sign-magnitude stream encoder/decoder family.
package sm_pkg;

   // Conversion width used by tc_to_sm; sm_encode_stream's WIDTH must equal it.
   localparam int SM_WIDTH = 9;

   // Most negative two's-complement value: the one input with no sign-magnitude form.
   localparam logic [SM_WIDTH-1:0] SM_MIN_TC = {1'b1, {(SM_WIDTH-1){1'b0}}};

   // Largest representable magnitude, used as the saturated result.
   localparam logic [SM_WIDTH-2:0] SM_MAX_MAG = '1;

   // Occupancy of the 2-entry skid buffer.
   typedef enum logic [1:0] {
      BUF_EMPTY = 2'd0,
      BUF_ONE   = 2'd1,
      BUF_FULL  = 2'd2
   } buf_state_t;

   // Encoded sample: saturation flag above the sign-magnitude word.
   typedef struct packed {
      logic                sat;
      logic [SM_WIDTH-1:0] sm;
   } sm_word_t;

   // Two's-complement to sign-magnitude. Zero maps to +0; the most negative
   // value clamps to the largest negative magnitude and flags sat.
   function automatic sm_word_t tc_to_sm(input logic [SM_WIDTH-1:0] x);
      sm_word_t            r;
      logic [SM_WIDTH-1:0] neg;
      neg   = -x;
      r.sat = (x == SM_MIN_TC);
      if (r.sat)
         r.sm = {1'b1, SM_MAX_MAG};
      else if (x[SM_WIDTH-1])
         r.sm = {1'b1, neg[SM_WIDTH-2:0]};
      else
         r.sm = x;
      return r;
   endfunction

endpackage

// File: rtl/sm_encode_stream_skid.sv
// Two-entry skid buffer with a registered s_ready, so backpressure from
// m_ready never reaches s_ready through combinational logic.
module sm_skid_buffer
   import sm_pkg::*;
#(
   parameter int W = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         s_valid,
   output logic         s_ready,
   input  logic [W-1:0] s_data,
   output logic         m_valid,
   input  logic         m_ready,
   output logic [W-1:0] m_data
);

   buf_state_t   state_q, state_d;
   logic         s_ready_q;
   logic [W-1:0] out_q;
   logic [W-1:0] skid_q;
   logic         in_xfer;
   logic         out_xfer;

   assign in_xfer  = s_valid && s_ready_q;
   assign out_xfer = (state_q != BUF_EMPTY) && m_ready;

   // State register; s_ready is registered from the next occupancy and held low during reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state_q   <= BUF_EMPTY;
         s_ready_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         s_ready_q <= (state_d != BUF_FULL);
      end
   end

   // Next-state logic from the occupancy rules.
   always_comb begin
      // NOTE: default assignment first so no path through the case leaves state_d unassigned (no latch).
      state_d = state_q;
      unique case (state_q)
         BUF_EMPTY: if (in_xfer) state_d = BUF_ONE;
         BUF_ONE: begin
            if (in_xfer && !out_xfer)      state_d = BUF_FULL;
            else if (!in_xfer && out_xfer) state_d = BUF_EMPTY;
         end
         BUF_FULL:  if (out_xfer) state_d = BUF_ONE;
         default:   state_d = BUF_EMPTY;
      endcase
   end

   // Output register: loads a new sample when empty or draining, or the skid entry when full drains.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_q <= '0;
      end else if (state_q == BUF_FULL) begin
         if (out_xfer) out_q <= skid_q;
      end else if (in_xfer && ((state_q == BUF_EMPTY) || out_xfer)) begin
         out_q <= s_data;
      end
   end

   // Skid register: parks a sample that arrives while the output is stalled.
   always_ff @(posedge clk) begin
      // NOTE: skid_q is not reset; it is only read in BUF_FULL, which reset makes unreachable until rewritten.
      if (!rst && (state_q == BUF_ONE) && in_xfer && !out_xfer) skid_q <= s_data;
   end

   // Output decode from occupancy.
   always_comb begin
      m_valid = (state_q != BUF_EMPTY);
      m_data  = out_q;
      s_ready = s_ready_q;
   end

endmodule

// File: rtl/sm_encode_stream.sv
// Streaming two's-complement to sign-magnitude encoder with saturation counting.
// Conversion happens at input acceptance; the skid buffer carries {sat, sm}.
module sm_encode_stream
   import sm_pkg::*;
#(
   parameter int WIDTH     = SM_WIDTH,
   parameter int SAT_CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [WIDTH-1:0]     s_data,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [WIDTH-1:0]     m_data,
   output logic                 m_sat,
   input  logic                 clr_count,
   output logic [SAT_CNT_W-1:0] sat_count
);

   localparam logic [SAT_CNT_W-1:0] CNT_MAX = '1;

   sm_word_t       enc;
   logic [WIDTH:0] buf_out;
   logic           in_xfer;
   logic           in_sat;

   assign enc     = tc_to_sm(s_data);
   assign in_xfer = s_valid && s_ready;
   assign in_sat  = in_xfer && enc.sat;

   sm_skid_buffer #(.W(WIDTH + 1)) u_skid (
      .clk     (clk),
      .rst     (rst),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_data  (enc),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (buf_out)
   );

   assign m_sat  = buf_out[WIDTH];
   assign m_data = buf_out[WIDTH-1:0];

   // Saturation counter: counts accepted saturating samples, sticks at all-ones, clear wins over hold.
   always_ff @(posedge clk) begin
      if (rst)
         sat_count <= '0;
      else if (clr_count)
         sat_count <= in_sat ? SAT_CNT_W'(1) : '0;
      else if (in_sat && (sat_count != CNT_MAX))
         sat_count <= sat_count + 1'b1;
   end

endmodule
